// File: rtl/cache_set_controller.sv
// Per-set cache controller: tag lookup, victim choice, writeback/fill, way updates.
// Optional hit/miss counters are built when CACHE_SET_CTRL_STATS_EN is defined.
module cache_set_controller #(
  parameter int NUM_WAYS      = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int BLOCK_SIZE    = 32,
  localparam int OFF_W = $clog2(BLOCK_SIZE),
  localparam int TAG_W = ADDRESS_WIDTH - OFF_W,
  localparam int AGE_W = $clog2(NUM_WAYS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [ADDRESS_WIDTH-1:0]      req_addr,
  input  logic [DATA_WIDTH-1:0]         req_wdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_hit,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  input  logic [NUM_WAYS*TAG_W-1:0]     way_tag,
  input  logic [NUM_WAYS-1:0]           way_valid,
  input  logic [NUM_WAYS-1:0]           way_dirty,
  input  logic [NUM_WAYS-1:0]           way_expired,
  input  logic [NUM_WAYS*AGE_W-1:0]     way_age,
  input  logic [NUM_WAYS*DATA_WIDTH-1:0] way_dout,
  output logic [NUM_WAYS-1:0]           way_allocate,
  output logic [NUM_WAYS-1:0]           way_wen,
  output logic [ADDRESS_WIDTH-1:0]      way_addr,
  output logic [DATA_WIDTH-1:0]         way_din,
  output logic                          accessed,
  output logic [AGE_W-1:0]              accessed_age,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic                          mem_we,
  output logic [ADDRESS_WIDTH-1:0]      mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic                          mem_rvalid,
  input  logic [DATA_WIDTH-1:0]         mem_rdata
`ifdef CACHE_SET_CTRL_STATS_EN
  ,
  output logic [31:0]                   hit_count,
  output logic [31:0]                   miss_count
`endif
);

  localparam int IDX_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    FILL,
    ALLOC,
    UPDATE,
    RESPOND
  } state_t;

  state_t                   state_q, state_d;
  logic                     we_q, we_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [IDX_W-1:0]         victim_q, victim_d;
  logic                     hit_q, hit_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic [ADDRESS_WIDTH-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_WIDTH-1:0]    wb_data_q, wb_data_d;
  logic                     fill_sent_q, fill_sent_d;
  logic [DATA_WIDTH-1:0]    fill_data_q, fill_data_d;

  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic             inv_found;
  logic [IDX_W-1:0] inv_idx;
  logic             exp_found;
  logic [IDX_W-1:0] exp_idx;
  logic [IDX_W-1:0] vic_idx;
  logic [TAG_W-1:0] req_tag;

  assign req_tag = addr_q[ADDRESS_WIDTH-1:OFF_W];

  // Tag compare across valid ways; scanning downward leaves the lowest match.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (way_valid[i] && (way_tag[i*TAG_W +: TAG_W] == req_tag)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Victim: lowest invalid way, else lowest expired way, else the last way.
  always_comb begin
    inv_found = 1'b0;
    inv_idx   = '0;
    exp_found = 1'b0;
    exp_idx   = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!way_valid[i]) begin
        inv_found = 1'b1;
        inv_idx   = IDX_W'(i);
      end
      if (way_expired[i]) begin
        exp_found = 1'b1;
        exp_idx   = IDX_W'(i);
      end
    end
    if (inv_found) begin
      vic_idx = inv_idx;
    end else if (exp_found) begin
      vic_idx = exp_idx;
    end else begin
      vic_idx = IDX_W'(NUM_WAYS - 1);
    end
  end

  // Next-state and output decode for the request sequencer.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    victim_d    = victim_q;
    hit_d       = hit_q;
    rdata_d     = rdata_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    fill_sent_d = fill_sent_q;
    fill_data_d = fill_data_q;

    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    rsp_hit       = 1'b0;
    rsp_rdata     = '0;
    way_allocate  = '0;
    way_wen       = '0;
    way_addr      = '0;
    way_din       = '0;
    accessed      = 1'b0;
    accessed_age  = '0;
    mem_req_valid = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          accessed     = 1'b1;
          accessed_age = way_age[int'(hit_idx)*AGE_W +: AGE_W];
          rsp_hit      = 1'b1;
          hit_d        = 1'b1;
          if (we_q) begin
            way_wen[hit_idx] = 1'b1;
            way_addr         = addr_q;
            way_din          = wdata_q;
            rdata_d          = '0;
          end else begin
            rsp_rdata = way_dout[int'(hit_idx)*DATA_WIDTH +: DATA_WIDTH];
            rdata_d   = way_dout[int'(hit_idx)*DATA_WIDTH +: DATA_WIDTH];
          end
          state_d = RESPOND;
        end else begin
          hit_d       = 1'b0;
          victim_d    = vic_idx;
          wb_addr_d   = {way_tag[int'(vic_idx)*TAG_W +: TAG_W], {OFF_W{1'b0}}};
          wb_data_d   = way_dout[int'(vic_idx)*DATA_WIDTH +: DATA_WIDTH];
          fill_sent_d = 1'b0;
          if (way_valid[vic_idx] && way_dirty[vic_idx]) begin
            state_d = WRITEBACK;
          end else begin
            state_d = FILL;
          end
        end
      end
      WRITEBACK: begin
        mem_req_valid = 1'b1;
        mem_we        = 1'b1;
        mem_addr      = wb_addr_q;
        mem_wdata     = wb_data_q;
        if (mem_req_ready) begin
          state_d = FILL;
        end
      end
      FILL: begin
        if (!fill_sent_q) begin
          mem_req_valid = 1'b1;
          mem_addr      = {req_tag, {OFF_W{1'b0}}};
          if (mem_req_ready) begin
            fill_sent_d = 1'b1;
          end
        end else if (mem_rvalid) begin
          fill_data_d = mem_rdata;
          state_d     = ALLOC;
        end
      end
      ALLOC: begin
        way_allocate[victim_q] = 1'b1;
        way_addr               = addr_q;
        accessed               = 1'b1;
        accessed_age           = way_age[int'(victim_q)*AGE_W +: AGE_W];
        state_d                = UPDATE;
      end
      UPDATE: begin
        way_wen[victim_q] = 1'b1;
        way_addr          = addr_q;
        way_din           = we_q ? wdata_q : fill_data_q;
        rsp_rdata         = fill_data_q;
        rdata_d           = fill_data_q;
        hit_d             = 1'b0;
        state_d           = RESPOND;
      end
      RESPOND: begin
        rsp_valid = 1'b1;
        rsp_hit   = hit_q;
        rsp_rdata = rdata_q;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and request context registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      victim_q    <= '0;
      hit_q       <= 1'b0;
      rdata_q     <= '0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      fill_sent_q <= 1'b0;
      fill_data_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      victim_q    <= victim_d;
      hit_q       <= hit_d;
      rdata_q     <= rdata_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      fill_sent_q <= fill_sent_d;
      fill_data_q <= fill_data_d;
    end
  end

`ifdef CACHE_SET_CTRL_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  // Saturating counters bumped once per lookup outcome.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == LOOKUP) begin
      if (hit) begin
        if (hit_count_q != '1) hit_count_d = hit_count_q + 32'd1;
      end else begin
        if (miss_count_q != '1) miss_count_d = miss_count_q + 32'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_set_controller.sv
// Directed bench for cache_set_controller: vector table of full
// transactions plus hand-written stall, reset and backpressure sequences.
module tb_cache_set_controller;
  localparam int NW = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TW = 27;
  localparam logic [31:0] D0 = 32'hAAAA0000;
  localparam logic [31:0] D1 = 32'hBBBB1111;
  localparam logic [31:0] D2 = 32'hCAFEF00D;
  localparam logic [31:0] D3 = 32'hDDDD3333;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              req_valid, req_ready, req_we;
  logic [AW-1:0]     req_addr;
  logic [DW-1:0]     req_wdata;
  logic              rsp_valid, rsp_ready, rsp_hit;
  logic [DW-1:0]     rsp_rdata;
  logic [NW*TW-1:0]  way_tag;
  logic [NW-1:0]     way_valid, way_dirty, way_expired;
  logic [NW*2-1:0]   way_age;
  logic [NW*DW-1:0]  way_dout;
  logic [NW-1:0]     way_allocate, way_wen;
  logic [AW-1:0]     way_addr;
  logic [DW-1:0]     way_din;
  logic              accessed;
  logic [1:0]        accessed_age;
  logic              mem_req_valid, mem_req_ready, mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              mem_rvalid;
  logic [DW-1:0]     mem_rdata;
`ifdef CACHE_SET_CTRL_STATS_EN
  logic [31:0]       hit_count, miss_count;
`endif

  logic [NW-1:0][TW-1:0] tags_v;
  assign way_tag  = tags_v;
  assign way_age  = {2'd0, 2'd3, 2'd2, 2'd1};
  assign way_dout = {D3, D2, D1, D0};

  cache_set_controller dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .rsp_rdata(rsp_rdata),
    .way_tag(way_tag), .way_valid(way_valid), .way_dirty(way_dirty),
    .way_expired(way_expired), .way_age(way_age), .way_dout(way_dout),
    .way_allocate(way_allocate), .way_wen(way_wen), .way_addr(way_addr),
    .way_din(way_din), .accessed(accessed), .accessed_age(accessed_age),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef CACHE_SET_CTRL_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", n, act, exp);
    end
  endtask

  typedef struct {
    string        name;
    logic         we;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [31:0]  fill;
    logic [3:0]   vld;
    logic [3:0]   drt;
    logic [3:0]   exp;
    logic [3:0][TW-1:0] tags;
    logic         e_hit;
    logic [1:0]   e_age;
    logic [3:0]   e_alloc;
    logic [3:0]   e_wen;
    logic [31:0]  e_din;
    logic         e_wb;
    logic [31:0]  e_wb_addr;
    logic [31:0]  e_wb_data;
    logic [31:0]  e_rdata;
    int           e_lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input string n, input logic we, input logic [31:0] addr,
    input logic [31:0] wdata, input logic [31:0] fill,
    input logic [3:0] vld, input logic [3:0] drt, input logic [3:0] exp,
    input logic [TW-1:0] t0, input logic [TW-1:0] t1,
    input logic [TW-1:0] t2, input logic [TW-1:0] t3,
    input logic e_hit, input logic [1:0] e_age,
    input logic [3:0] e_alloc, input logic [3:0] e_wen,
    input logic [31:0] e_din, input logic e_wb,
    input logic [31:0] e_wb_addr, input logic [31:0] e_wb_data,
    input logic [31:0] e_rdata, input int e_lat);
    vec_t v;
    v.name = n; v.we = we; v.addr = addr; v.wdata = wdata; v.fill = fill;
    v.vld = vld; v.drt = drt; v.exp = exp;
    v.tags = {t3, t2, t1, t0};
    v.e_hit = e_hit; v.e_age = e_age; v.e_alloc = e_alloc;
    v.e_wen = e_wen; v.e_din = e_din; v.e_wb = e_wb;
    v.e_wb_addr = e_wb_addr; v.e_wb_data = e_wb_data;
    v.e_rdata = e_rdata; v.e_lat = e_lat;
    return v;
  endfunction

  task automatic set_ways(input logic [3:0][TW-1:0] t, input logic [3:0] v,
                          input logic [3:0] d, input logic [3:0] e);
    tags_v = t; way_valid = v; way_dirty = d; way_expired = e;
  endtask

  task automatic start_req(input string n, input logic we,
                           input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
    @(negedge clk);
    chk({n, " req_ready"}, req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string n, output int cyc);
    cyc = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        cyc = i;
        break;
      end
      @(posedge clk); #1;
    end
    chk({n, " rsp_valid"}, rsp_valid, 1);
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic chk_quiet(input string n);
    chk({n, " req_ready"}, req_ready, 1);
    chk({n, " rsp_valid"}, rsp_valid, 0);
    chk({n, " rsp_hit"}, rsp_hit, 0);
    chk({n, " rsp_rdata"}, rsp_rdata, 0);
    chk({n, " mem_req_valid"}, mem_req_valid, 0);
    chk({n, " mem_we"}, mem_we, 0);
    chk({n, " mem_addr"}, mem_addr, 0);
    chk({n, " mem_wdata"}, mem_wdata, 0);
    chk({n, " way_allocate"}, way_allocate, 0);
    chk({n, " way_wen"}, way_wen, 0);
    chk({n, " way_addr"}, way_addr, 0);
    chk({n, " way_din"}, way_din, 0);
    chk({n, " accessed"}, accessed, 0);
    chk({n, " accessed_age"}, accessed_age, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int         lat = 0;
    int         rv_at = -1;
    int         acc_n = 0;
    int         wb_n = 0;
    int         fill_n = 0;
    logic [1:0] acc_age = '0;
    logic [3:0] alloc_or = '0;
    logic [3:0] wen_or = '0;
    logic [31:0] din_last = '0;
    logic [31:0] wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic [31:0] fill_addr = '0;
    logic       excl_bad = 1'b0;
    set_ways(v.tags, v.vld, v.drt, v.exp);
    mem_rdata = v.fill;
    start_req(v.name, v.we, v.addr, v.wdata);
    for (int c = 1; c <= 40; c++) begin
      mem_rvalid = (c == rv_at);
      @(negedge clk);
      if ((way_allocate != 0) && (way_wen != 0)) excl_bad = 1'b1;
      if ($countones(way_allocate) > 1) excl_bad = 1'b1;
      if ($countones(way_wen) > 1) excl_bad = 1'b1;
      alloc_or |= way_allocate;
      if (way_wen != 0) begin
        wen_or |= way_wen;
        din_last = way_din;
      end
      if (accessed) begin
        acc_n++;
        acc_age = accessed_age;
      end
      if (mem_req_valid && mem_req_ready) begin
        if (mem_we) begin
          wb_n++;
          wb_addr = mem_addr;
          wb_data = mem_wdata;
        end else begin
          fill_n++;
          fill_addr = mem_addr;
          rv_at = c + 2;
        end
      end
      if (rsp_valid) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b0;
    chk({v.name, " latency"}, lat, v.e_lat);
    chk({v.name, " rsp_hit"}, rsp_hit, v.e_hit);
    if (!(v.we && v.e_hit)) chk({v.name, " rsp_rdata"}, rsp_rdata, v.e_rdata);
    chk({v.name, " accessed_pulses"}, acc_n, 1);
    chk({v.name, " accessed_age"}, acc_age, v.e_age);
    chk({v.name, " way_allocate"}, alloc_or, v.e_alloc);
    chk({v.name, " way_wen"}, wen_or, v.e_wen);
    if (v.e_wen != 0) chk({v.name, " way_din"}, din_last, v.e_din);
    chk({v.name, " onehot_excl"}, excl_bad, 0);
    chk({v.name, " writebacks"}, wb_n, v.e_wb ? 1 : 0);
    if (v.e_wb) begin
      chk({v.name, " wb_addr"}, wb_addr, v.e_wb_addr);
      chk({v.name, " wb_data"}, wb_data, v.e_wb_data);
    end
    chk({v.name, " fills"}, fill_n, v.e_hit ? 0 : 1);
    if (!v.e_hit) chk({v.name, " fill_addr"}, fill_addr, {v.addr[31:5], 5'b0});
    drain();
  endtask

  initial begin
    int cyc;
    logic [3:0][TW-1:0] t;
    reset = 1'b1;
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
    rsp_ready = 0;
    mem_req_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
    tags_v = '0; way_valid = '0; way_dirty = '0; way_expired = '0;

    vecs.push_back(mk("read_hit", 0, 32'h00002460, 0, 0,
      4'b0100, 4'b0000, 4'b0000, 27'hAAA, 27'hBBB, 27'h123, 27'hDDD,
      1, 2'd3, 4'b0000, 4'b0000, 0, 0, 0, 0, D2, 2));
    vecs.push_back(mk("clean_miss", 0, 32'h00002460, 0, 32'h11223344,
      4'b1101, 4'b0000, 4'b0000, 27'hAAA, 27'hBBB, 27'h0FF, 27'hDDD,
      0, 2'd2, 4'b0010, 4'b0010, 32'h11223344, 0, 0, 0, 32'h11223344, 7));
    vecs.push_back(mk("dirty_miss", 0, 32'h00004000, 0, 32'h55667788,
      4'b1111, 4'b1000, 4'b1000, 27'hAAA, 27'hBBB, 27'hCCC, 27'h001,
      0, 2'd0, 4'b1000, 4'b1000, 32'h55667788, 1, 32'h00000020, D3,
      32'h55667788, 8));
    vecs.push_back(mk("write_hit", 1, 32'h00000EE4, 32'hDEADBEEF, 0,
      4'b0001, 4'b0000, 4'b0000, 27'h077, 27'hBBB, 27'hCCC, 27'hDDD,
      1, 2'd1, 4'b0000, 4'b0001, 32'hDEADBEEF, 0, 0, 0, 0, 2));
    vecs.push_back(mk("prio_way0", 0, 32'h00000A04, 0, 0,
      4'b1011, 4'b0000, 4'b0000, 27'h050, 27'h050, 27'hCCC, 27'h050,
      1, 2'd1, 4'b0000, 4'b0000, 0, 0, 0, 0, D0, 2));
    vecs.push_back(mk("prio_way1", 0, 32'h00000A04, 0, 0,
      4'b1010, 4'b0000, 4'b0000, 27'h050, 27'h050, 27'hCCC, 27'h050,
      1, 2'd2, 4'b0000, 4'b0000, 0, 0, 0, 0, D1, 2));
    vecs.push_back(mk("invalid_over_expired", 0, 32'h00002460, 0,
      32'h01010101, 4'b1011, 4'b0001, 4'b0001,
      27'hAAA, 27'hBBB, 27'hCCC, 27'hDDD,
      0, 2'd3, 4'b0100, 4'b0100, 32'h01010101, 0, 0, 0, 32'h01010101, 7));
    vecs.push_back(mk("lowest_expired_dirty", 0, 32'h00002460, 0,
      32'h02020202, 4'b1111, 4'b0010, 4'b0110,
      27'hAAA, 27'hBBB, 27'hCCC, 27'hDDD,
      0, 2'd2, 4'b0010, 4'b0010, 32'h02020202, 1, 32'h00017760, D1,
      32'h02020202, 8));
    vecs.push_back(mk("default_way3_write", 1, 32'h00008008, 32'h12345678,
      32'h0F0F0F0F, 4'b1111, 4'b1000, 4'b0000,
      27'hAAA, 27'hBBB, 27'hCCC, 27'hABCDEF,
      0, 2'd0, 4'b1000, 4'b1000, 32'h12345678, 1, 32'h1579BDE0, D3,
      32'h0F0F0F0F, 8));
    vecs.push_back(mk("invalid_tag_ignored", 0, 32'h00002460, 0,
      32'h03030303, 4'b1011, 4'b0000, 4'b0000,
      27'hAAA, 27'hBBB, 27'h123, 27'hDDD,
      0, 2'd3, 4'b0100, 4'b0100, 32'h03030303, 0, 0, 0, 32'h03030303, 7));
    vecs.push_back(mk("default_way3_clean", 0, 32'h00002460, 0,
      32'h04040404, 4'b1111, 4'b0111, 4'b0000,
      27'hAAA, 27'hBBB, 27'hCCC, 27'hDDD,
      0, 2'd0, 4'b1000, 4'b1000, 32'h04040404, 0, 0, 0, 32'h04040404, 7));

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk_quiet("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Writeback stalled by memory for three cycles.
    t = {27'h001, 27'hCCC, 27'hBBB, 27'hAAA};
    set_ways(t, 4'b1111, 4'b1000, 4'b1000);
    mem_req_ready = 1'b0;
    start_req("stall", 0, 32'h00004000, 0);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall wb_ctrl", {mem_req_valid, mem_we}, 2'b11);
      chk("stall wb_addr", mem_addr, 32'h00000020);
      chk("stall wb_data", mem_wdata, D3);
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk("stall wb_accept_addr", mem_addr, 32'h00000020);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall fill_ctrl", {mem_req_valid, mem_we}, 2'b10);
    chk("stall fill_addr", mem_addr, 32'h00004000);
    @(posedge clk); #1;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h99999999;
    wait_rsp("stall", cyc);
    mem_rvalid = 1'b0;
    chk("stall rsp_rdata", rsp_rdata, 32'h99999999);
    chk("stall rsp_hit", rsp_hit, 0);
    drain();

    // Reset while a fill response is outstanding.
    t = {27'hDDD, 27'h0FF, 27'hBBB, 27'hAAA};
    set_ways(t, 4'b1101, 4'b0000, 4'b0000);
    start_req("rst_fill", 0, 32'h00002460, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_fill fill_req", mem_req_valid, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h77777777;
    @(negedge clk);
    chk_quiet("rst_fill");
    @(posedge clk); #1;
    reset = 1'b0;
    mem_rvalid = 1'b0;

    // Read hit after reset with the response held off.
    t = {27'hDDD, 27'h123, 27'hBBB, 27'hAAA};
    set_ways(t, 4'b0100, 4'b0000, 4'b0000);
    start_req("post_rst", 0, 32'h00002460, 0);
    wait_rsp("post_rst", cyc);
    chk("post_rst latency", cyc, 2);
    chk("post_rst rsp_hit", rsp_hit, 1);
    chk("post_rst rsp_rdata", rsp_rdata, D2);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold rsp_valid", rsp_valid, 1);
      chk("hold rsp_rdata", rsp_rdata, D2);
      chk("hold rsp_hit", rsp_hit, 1);
    end
    drain();
    @(negedge clk);
    chk("after_rsp rsp_valid", rsp_valid, 0);
    chk("after_rsp req_ready", req_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
